// File: rtl/ps2_mouse_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_mouse_decoder_if
//   Bundle between the PS/2 byte recorder and the mouse packet decoder.
//
//   Signals:
//     record        [23:0] packet bytes: [23:16] status, [15:8] X, [7:0] Y
//     finished             level, high while a complete packet is in record
//     x             [9:0]  cursor x, 0..X_MAX
//     y             [8:0]  cursor y, 0..Y_MAX
//     btn_left/right/middle  button states
//     packet_valid         1-cycle pulse, packet applied
//     left_click           1-cycle pulse, left button 0->1
//     sync_error           1-cycle pulse, packet rejected
//
//   Modports:
//     master : recorder / game side (drives record and finished)
//     slave  : decoder side (drives cursor, buttons and event pulses)
// ---------------------------------------------------------------------------
interface ps2_mouse_decoder_if;
  logic [23:0] record;
  logic        finished;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        btn_left;
  logic        btn_right;
  logic        btn_middle;
  logic        packet_valid;
  logic        left_click;
  logic        sync_error;

  modport master (
    output record, finished,
    input  x, y, btn_left, btn_right, btn_middle,
           packet_valid, left_click, sync_error
  );

  modport slave (
    input  record, finished,
    output x, y, btn_left, btn_right, btn_middle,
           packet_valid, left_click, sync_error
  );
endinterface

// File: rtl/ps2_mouse_decoder.sv
// ---------------------------------------------------------------------------
// ps2_mouse_decoder
//   Takes the 3-byte PS/2 mouse packet presented by the byte recorder, checks
//   it, updates the button states and integrates the X/Y deltas into a
//   clamped screen cursor. Emits single-cycle event pulses for the game logic.
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset
//     bus    slave modport of ps2_mouse_decoder_if (record/finished in,
//            cursor, buttons and event pulses out)
//
//   Optional feature:
//     MOUSE_ACCEL_EN  when defined, deltas with |delta| >= ACCEL_THRESH are
//                     doubled before being applied to the cursor.
// ---------------------------------------------------------------------------
module ps2_mouse_decoder #(
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int X_INIT       = 320,
  parameter int Y_INIT       = 240,
  parameter int ACCEL_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_mouse_decoder_if.slave    bus
);

`ifdef MOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
  localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);
  localparam logic signed [11:0] THRESH  = 12'(ACCEL_THRESH);

  typedef enum logic [1:0] {IDLE, LATCH, CHECK, UPDATE} state_e;

  state_e             state_q;
  logic [23:0]        pkt_q;
  logic               finished_q;   // finished delayed by one clk
  logic signed [11:0] dx_q, dy_q;
  logic [9:0]         x_q;
  logic [8:0]         y_q;
  logic [2:0]         btn_q;        // {middle, right, left}
  logic               packet_valid_q, left_click_q, sync_error_q;

  logic               start;
  logic signed [11:0] dx_eff, dy_eff, nx, ny;
  logic [9:0]         x_d;
  logic [8:0]         y_d;

  assign start = bus.finished & ~finished_q;

  function automatic logic is_big(input logic signed [11:0] d);
    return (d != 12'sd0) && ((d >= THRESH) || (d <= -THRESH));
  endfunction

  // Next cursor position; y is subtracted because PS/2 Y grows upward while
  // screen y grows downward. 12-bit signed width cannot wrap for any delta.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    dx_eff = dx_q;
    dy_eff = dy_q;
    if (ACCEL_ON && is_big(dx_q)) dx_eff = dx_q <<< 1;
    if (ACCEL_ON && is_big(dy_q)) dy_eff = dy_q <<< 1;

    nx = $signed({2'b00, x_q}) + dx_eff;
    ny = $signed({3'b000, y_q}) - dy_eff;

    if (nx < 12'sd0)       x_d = '0;
    else if (nx > X_MAX_S) x_d = X_MAX_S[9:0];
    else                   x_d = nx[9:0];

    if (ny < 12'sd0)       y_d = '0;
    else if (ny > Y_MAX_S) y_d = Y_MAX_S[8:0];
    else                   y_d = ny[8:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pkt_q          <= '0;
      // Held high so a finished already asserted at reset release is not
      // mistaken for a fresh packet.
      finished_q     <= 1'b1;
      dx_q           <= '0;
      dy_q           <= '0;
      x_q            <= 10'(X_INIT);
      y_q            <= 9'(Y_INIT);
      btn_q          <= '0;
      packet_valid_q <= 1'b0;
      left_click_q   <= 1'b0;
      sync_error_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      finished_q     <= bus.finished;
      packet_valid_q <= 1'b0;
      left_click_q   <= 1'b0;
      sync_error_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          // Starts arriving in any other state are dropped; pkt_q is kept.
          if (start) begin
            pkt_q   <= bus.record;
            state_q <= LATCH;
          end
        end
        LATCH: begin
          // 9-bit two's complement deltas: sign bits live in the status byte.
          dx_q    <= {{4{pkt_q[20]}}, pkt_q[15:8]};
          dy_q    <= {{4{pkt_q[21]}}, pkt_q[7:0]};
          state_q <= CHECK;
        end
        CHECK: begin
          if (!pkt_q[19]) begin
            // Status bit 3 is always 1 in a well-framed packet.
            sync_error_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            if (pkt_q[22]) dx_q <= '0;
            if (pkt_q[23]) dy_q <= '0;
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          x_q            <= x_d;
          y_q            <= y_d;
          btn_q          <= {pkt_q[18], pkt_q[17], pkt_q[16]};
          packet_valid_q <= 1'b1;
          left_click_q   <= pkt_q[16] & ~btn_q[0];
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.btn_left     = btn_q[0];
  assign bus.btn_right    = btn_q[1];
  assign bus.btn_middle   = btn_q[2];
  assign bus.packet_valid = packet_valid_q;
  assign bus.left_click   = left_click_q;
  assign bus.sync_error   = sync_error_q;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_decoder
//   Table of packets with hand-computed cursor/button/pulse expectations,
//   followed by hand-written sequences for start-while-busy and reset
//   mid-packet with finished held high across reset release.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_mouse_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_mouse_decoder_if bus ();

  ps2_mouse_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] rec;
    int          hold;
    int          exp_x;
    int          exp_y;
    logic [2:0]  exp_btn;   // {middle, right, left}
    int          exp_pv;
    int          exp_lc;
    int          exp_se;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

`ifdef MOUSE_ACCEL_EN
  localparam int X_TAB = 404;
  localparam int Y_TAB = 193;
`else
  localparam int X_TAB = 5;
  localparam int Y_TAB = 479;
`endif

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [23:0] rec, input int hold,
                              input int ex, input int ey, input logic [2:0] eb,
                              input int pv, input int lc, input int se);
    vec_t v;
    v.rec = rec; v.hold = hold; v.exp_x = ex; v.exp_y = ey; v.exp_btn = eb;
    v.exp_pv = pv; v.exp_lc = lc; v.exp_se = se;
    return v;
  endfunction

  function automatic int btns();
    return {29'd0, bus.btn_middle, bus.btn_right, bus.btn_left};
  endfunction

  // Raise finished with rec, keep it high for 'hold' clk edges, then watch
  // the pulses for a few more cycles. pv_at is the edge index (counted from
  // the first edge that sees finished high) after which packet_valid showed.
  task automatic send(input logic [23:0] rec, input int hold,
                      output int n_pv, output int n_lc, output int n_se,
                      output int pv_at);
    n_pv = 0; n_lc = 0; n_se = 0; pv_at = -1;
    @(posedge clk); #1;
    bus.record   = rec;
    bus.finished = 1'b1;
    for (int i = 1; i <= hold + 8; i++) begin
      @(posedge clk);
      if (i == hold) begin #1; bus.finished = 1'b0; end
      @(negedge clk);
      if (bus.packet_valid) begin n_pv++; if (pv_at < 0) pv_at = i; end
      if (bus.left_click) n_lc++;
      if (bus.sync_error) n_se++;
    end
  endtask

  initial begin
    int n_pv, n_lc, n_se, pv_at;

`ifdef MOUSE_ACCEL_EN
    vecs.push_back(mk(24'h08_20_00, 4, 384, 240, 3'b000, 1, 0, 0));
    vecs.push_back(mk(24'h08_05_00, 4, 389, 240, 3'b000, 1, 0, 0));
    vecs.push_back(mk(24'h18_F0_00, 4, 357, 240, 3'b000, 1, 0, 0)); // -16 -> -32
    vecs.push_back(mk(24'h08_00_10, 4, 357, 208, 3'b000, 1, 0, 0)); // +16 -> +32 up
    vecs.push_back(mk(24'h08_00_0F, 4, 357, 193, 3'b000, 1, 0, 0)); // 15 not doubled
    vecs.push_back(mk(24'h08_10_00, 4, 389, 193, 3'b000, 1, 0, 0));
    vecs.push_back(mk(24'h08_0F_00, 4, 404, 193, 3'b000, 1, 0, 0));
`else
    vecs.push_back(mk(24'h08_0A_05, 4, 330, 235, 3'b000, 1, 0, 0));
    vecs.push_back(mk(24'h09_00_00, 4, 330, 235, 3'b001, 1, 1, 0));
    vecs.push_back(mk(24'h09_00_00, 4, 330, 235, 3'b001, 1, 0, 0));
    vecs.push_back(mk(24'h08_FF_00, 4, 585, 235, 3'b000, 1, 0, 0));
    vecs.push_back(mk(24'h08_2D_00, 4, 630, 235, 3'b000, 1, 0, 0));
    vecs.push_back(mk(24'h08_20_00, 4, 639, 235, 3'b000, 1, 0, 0)); // clamp hi
    vecs.push_back(mk(24'h18_00_00, 4, 383, 235, 3'b000, 1, 0, 0)); // dx=-256
    vecs.push_back(mk(24'h18_00_00, 4, 127, 235, 3'b000, 1, 0, 0));
    vecs.push_back(mk(24'h18_00_00, 4,   0, 235, 3'b000, 1, 0, 0)); // clamp lo
    vecs.push_back(mk(24'h00_10_00, 4,   0, 235, 3'b000, 0, 0, 1)); // bad sync
    vecs.push_back(mk(24'h48_7F_02, 50,  0, 233, 3'b000, 1, 0, 0)); // X ovf, long hold
    vecs.push_back(mk(24'h08_00_FF, 4,   0,   0, 3'b000, 1, 0, 0)); // y clamp lo
    vecs.push_back(mk(24'h28_00_00, 4,   0, 256, 3'b000, 1, 0, 0)); // dy=-256
    vecs.push_back(mk(24'h28_00_00, 4,   0, 479, 3'b000, 1, 0, 0)); // y clamp hi
    vecs.push_back(mk(24'h88_05_7F, 4,   5, 479, 3'b000, 1, 0, 0)); // Y ovf
    vecs.push_back(mk(24'h0E_00_00, 4,   5, 479, 3'b110, 1, 0, 0)); // R + M
    vecs.push_back(mk(24'h0F_00_00, 4,   5, 479, 3'b111, 1, 1, 0));
    vecs.push_back(mk(24'h01_00_00, 4,   5, 479, 3'b111, 0, 0, 1)); // rejected
`endif

    // Reset state.
    reset = 1'b1;
    bus.record   = '0;
    bus.finished = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.x",   int'(bus.x), 320);
    check("rst.y",   int'(bus.y), 240);
    check("rst.btn", btns(), 0);
    check("rst.pulses",
          int'(bus.packet_valid) + int'(bus.left_click) + int'(bus.sync_error), 0);

    // Table-driven packets.
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].rec, vecs[i].hold, n_pv, n_lc, n_se, pv_at);
      check($sformatf("v%0d.x", i),   int'(bus.x), vecs[i].exp_x);
      check($sformatf("v%0d.y", i),   int'(bus.y), vecs[i].exp_y);
      check($sformatf("v%0d.btn", i), btns(), int'(vecs[i].exp_btn));
      check($sformatf("v%0d.pv", i),  n_pv, vecs[i].exp_pv);
      check($sformatf("v%0d.lc", i),  n_lc, vecs[i].exp_lc);
      check($sformatf("v%0d.se", i),  n_se, vecs[i].exp_se);
      if (vecs[i].exp_pv == 1) check($sformatf("v%0d.lat", i), pv_at, 4);
    end

    // Start while busy: a second rising edge of finished arrives while the
    // first packet is in CHECK and must be ignored; pkt must not change.
    n_pv = 0;
    @(posedge clk); #1;
    bus.record   = 24'h08_01_00;
    bus.finished = 1'b1;
    @(posedge clk); #1;
    bus.finished = 1'b0;
    bus.record   = 24'h08_10_00;
    @(posedge clk); #1;
    bus.finished = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.packet_valid) n_pv++;
      @(posedge clk);
    end
    #1 bus.finished = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy.pv", n_pv, 1);
    check("busy.x",  int'(bus.x), X_TAB + 1);
    check("busy.y",  int'(bus.y), Y_TAB);

    // Reset mid-packet; finished stays high across reset release.
    n_pv = 0; n_se = 0;
    @(posedge clk); #1;
    bus.record   = 24'h08_05_00;
    bus.finished = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (bus.packet_valid) n_pv++;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst.x", int'(bus.x), 320);
    check("midrst.y", int'(bus.y), 240);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.packet_valid) n_pv++;
      if (bus.sync_error)   n_se++;
      @(posedge clk);
    end
    check("midrst.pv", n_pv, 0);
    check("midrst.se", n_se, 0);
    check("midrst.x_after", int'(bus.x), 320);
    #1 bus.finished = 1'b0;
    repeat (3) @(posedge clk);

    // Normal operation resumes after the aborted packet.
    send(24'h08_02_00, 4, n_pv, n_lc, n_se, pv_at);
    check("resume.pv",  n_pv, 1);
    check("resume.lat", pv_at, 4);
    check("resume.x",   int'(bus.x), 322);
    check("resume.y",   int'(bus.y), 240);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got stalled run expected completion");
    $fatal(1, "timeout");
  end

endmodule
